// File: rtl/culsans_usecase_soc_shell.sv
// Culsans simulation platform shell: DRAM, CLINT timer/IPI, and tohost exit register
// behind a single always-ready bus port with a fixed one-cycle response.
`timescale 1ns/1ps

module culsans_usecase_soc_shell_tc_sram #(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned IDX_W     = 10
) (
  input  logic             clk_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [63:0]      wdata_i,
  input  logic [7:0]       be_i,
  output logic [63:0]      rdata_o
);

  // Left uninitialised on purpose so benches can backdoor-load images into it.
  logic [63:0] sram [NUM_WORDS];

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int b = 0; b < 8; b++) begin
          if (be_i[b]) sram[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_o <= sram[addr_i];
    end
  end

endmodule

module culsans_usecase_soc_shell_sram #(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned IDX_W     = 10
) (
  input  logic             clk_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [63:0]      wdata_i,
  input  logic [7:0]       be_i,
  output logic [63:0]      rdata_o
);

  culsans_usecase_soc_shell_tc_sram #(
    .NUM_WORDS(NUM_WORDS),
    .IDX_W    (IDX_W)
  ) i_tc_sram (
    .clk_i  (clk_i),
    .req_i  (req_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .wdata_i(wdata_i),
    .be_i   (be_i),
    .rdata_o(rdata_o)
  );

endmodule

module culsans_usecase_soc_shell #(
  parameter logic        InclSimDTM  = 1'b0,
  parameter int unsigned NUM_WORDS   = 80*1024*1024,
  parameter logic [63:0] BootAddress = 64'h8000_0000,
  parameter logic [63:0] ToHostAddr  = 64'h0400_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rtc_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [63:0] rdata_o,
  output logic        err_o,
  output logic [63:0] boot_addr_o,
  output logic        timer_irq_o,
  output logic        ipi_o,
  output logic        debug_req_o,
  output logic [31:0] exit_o
);

  localparam logic [63:0] DRAM_BASE  = 64'h8000_0000;
  localparam logic [63:0] DRAM_END   = DRAM_BASE + 64'(NUM_WORDS) * 64'd8;
  localparam logic [63:0] CLINT_BASE = 64'h0200_0000;
  localparam int unsigned IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [63:0] addr_w, dram_off, be_mask, reg_rdata, dram_rdata;
  logic        sel_dram, sel_msip, sel_dbg, sel_cmp, sel_mtime, sel_exit, mapped, wr;
  logic        unused_bits;

  logic [2:0]  rtc_sync;
  logic        rtc_edge;
  logic [63:0] mtime_q, mtimecmp_q, rdata_q;
  logic        msip_q, dbg_q, timer_irq_q, debug_q;
  logic        rvalid_q, err_q, resp_dram_q;
  logic [31:0] exit_q;

  assign addr_w    = {addr_i[63:3], 3'b000};
  assign dram_off  = addr_w - DRAM_BASE;
  assign sel_dram  = (addr_w >= DRAM_BASE) && (addr_w < DRAM_END);
  assign sel_msip  = addr_w == CLINT_BASE;
  assign sel_dbg   = addr_w == CLINT_BASE + 64'h8;
  assign sel_cmp   = addr_w == CLINT_BASE + 64'h4000;
  assign sel_mtime = addr_w == CLINT_BASE + 64'hBFF8;
  assign sel_exit  = addr_w == {ToHostAddr[63:3], 3'b000};
  assign mapped    = sel_dram | sel_msip | sel_dbg | sel_cmp | sel_mtime | sel_exit;
  assign wr        = req_i & we_i;
  assign rtc_edge  = rtc_sync[1] & ~rtc_sync[2];
  assign unused_bits = ^{dram_off[63:IDX_W+3], dram_off[2:0]};

  always_comb begin
    be_mask   = '0;
    reg_rdata = '0;
    for (int b = 0; b < 8; b++) be_mask[8*b +: 8] = {8{be_i[b]}};
    if (sel_msip)       reg_rdata = {63'b0, msip_q};
    else if (sel_dbg)   reg_rdata = {63'b0, dbg_q};
    else if (sel_cmp)   reg_rdata = mtimecmp_q;
    else if (sel_mtime) reg_rdata = mtime_q;
    else if (sel_exit)  reg_rdata = {32'b0, exit_q};
  end

  culsans_usecase_soc_shell_sram #(
    .NUM_WORDS(NUM_WORDS),
    .IDX_W    (IDX_W)
  ) i_sram (
    .clk_i  (clk_i),
    .req_i  (req_i & sel_dram),
    .we_i   (we_i),
    .addr_i (dram_off[IDX_W+2:3]),
    .wdata_i(wdata_i),
    .be_i   (be_i),
    .rdata_o(dram_rdata)
  );

  // A bus write to mtime takes priority over an RTC tick landing in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rtc_sync    <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      dbg_q       <= 1'b0;
      exit_q      <= '0;
      timer_irq_q <= 1'b0;
      debug_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      resp_dram_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rtc_sync    <= {rtc_sync[1:0], rtc_i};
      timer_irq_q <= mtime_q >= mtimecmp_q;
      debug_q     <= InclSimDTM & dbg_q;
      rvalid_q    <= req_i;
      err_q       <= req_i & ~mapped;
      resp_dram_q <= req_i & ~we_i & sel_dram;
      rdata_q     <= (req_i & ~we_i) ? reg_rdata : '0;

      if (wr && sel_mtime)  mtime_q <= (mtime_q & ~be_mask) | (wdata_i & be_mask);
      else if (rtc_edge)    mtime_q <= mtime_q + 64'd1;
      if (wr && sel_cmp)    mtimecmp_q <= (mtimecmp_q & ~be_mask) | (wdata_i & be_mask);
      if (wr && sel_msip && be_i[0]) msip_q <= wdata_i[0];
      if (wr && sel_dbg  && be_i[0]) dbg_q  <= wdata_i[0];
      // Once the done bit is set the exit code is frozen until reset.
      if (wr && sel_exit && !exit_q[0] && |be_i[3:0])
        exit_q <= (exit_q & ~be_mask[31:0]) | (wdata_i[31:0] & be_mask[31:0]);
    end
  end

  assign gnt_o       = req_i;
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rvalid_q ? (resp_dram_q ? dram_rdata : rdata_q) : '0;
  assign boot_addr_o = BootAddress;
  assign timer_irq_o = timer_irq_q;
  assign ipi_o       = msip_q;
  assign debug_req_o = debug_q;
  assign exit_o      = exit_q;

endmodule

// File: tb/tb_culsans_usecase_soc_shell.sv
// Self-checking bench for culsans_usecase_soc_shell: randomized bus traffic against
// a word-level memory/CLINT/exit reference model.
`timescale 1ns/1ps

module tb_culsans_usecase_soc_shell;

  localparam int unsigned NW        = 4096;
  localparam logic [63:0] DRAM_BASE = 64'h8000_0000;
  localparam logic [63:0] CLINT     = 64'h0200_0000;
  localparam logic [63:0] TOHOST    = 64'h0400_0000;

  logic        clk = 1'b0, rst_n = 1'b0, rtc = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic [7:0]  be = '0;
  logic        gnt, rvalid, err, timer_irq, ipi, debug_req;
  logic [63:0] rdata, boot_addr;
  logic [31:0] exit_val;

  int checks = 0, errors = 0;

  logic [63:0] mem_model [int];
  logic [63:0] m_mtime;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] exp;
    logic        exp_err;
  } op_t;

  culsans_usecase_soc_shell #(.NUM_WORDS(NW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rtc_i(rtc), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .boot_addr_o(boot_addr), .timer_irq_o(timer_irq),
    .ipi_o(ipi), .debug_req_o(debug_req), .exit_o(exit_val)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] b);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic do_reset();
    req = 1'b0; rtc = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_mtime = '0;
  endtask

  task automatic access(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] b, output logic [63:0] rd, output logic er,
                        output logic vl);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    vl = rvalid; rd = rdata; er = err;
    req = 1'b0;
  endtask

  task automatic rtc_pulse();
    rtc = 1'b1; repeat (4) @(negedge clk);
    rtc = 1'b0; repeat (4) @(negedge clk);
    m_mtime = m_mtime + 64'd1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (exit_val !== 32'h0) begin errors++; $display("[TB] FAIL reset_exit got %h want 0", exit_val); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_timer got %b want 0", timer_irq); end
    checks++; if (boot_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL reset_boot got %h want 80000000", boot_addr); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid got %b want 0", rvalid); end
    checks++; if ({ipi, debug_req, err, gnt} !== 4'b0) begin errors++; $display("[TB] FAIL reset_misc got %b want 0000", {ipi, debug_req, err, gnt}); end
    checks++; if (rdata !== 64'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", rdata); end
  endtask

  task automatic test_dram_basic();
    logic [63:0] rd; logic er, vl;
    dut.i_sram.i_tc_sram.sram[0] = 64'hDEAD_BEEF_0123_4567;
    mem_model[0] = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = DRAM_BASE; be = 8'hFF;
    #1;
    checks++; if (gnt !== 1'b1) begin errors++; $display("[TB] FAIL gnt got %b want 1", gnt); end
    @(negedge clk);
    vl = rvalid; rd = rdata; er = err; req = 1'b0;
    checks++; if ({vl, er} !== 2'b10) begin errors++; $display("[TB] FAIL dram_rd_flags got %b want 10", {vl, er}); end
    checks++; if (rd !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("[TB] FAIL dram_rd_data got %h want deadbeef01234567", rd); end
    @(negedge clk);
    checks++; if (rvalid !== 1'b0 || rdata !== 64'h0) begin errors++; $display("[TB] FAIL rvalid_pulse got %b/%h want 0/0", rvalid, rdata); end
    access(1'b1, DRAM_BASE + 64'h8, 64'h0, 8'hFF, rd, er, vl);
    access(1'b1, DRAM_BASE + 64'h8, 64'h1111_2222_3333_4444, 8'h0F, rd, er, vl);
    checks++; if ({vl, er} !== 2'b10) begin errors++; $display("[TB] FAIL dram_wr_resp got %b want 10", {vl, er}); end
    access(1'b0, DRAM_BASE + 64'h8, 64'h0, 8'hFF, rd, er, vl);
    mem_model[1] = 64'h0000_0000_3333_4444;
    checks++; if (rd !== 64'h0000_0000_3333_4444) begin errors++; $display("[TB] FAIL dram_be got %h want 0000000033334444", rd); end
  endtask

  task automatic test_dram_random();
    logic [63:0] rd, d; logic er, vl; int idx; logic [7:0] b;
    for (int i = 16; i < 32; i++) begin
      d = {$urandom, $urandom};
      access(1'b1, DRAM_BASE + 64'(i) * 8, d, 8'hFF, rd, er, vl);
      mem_model[i] = d;
    end
    for (int n = 0; n < 60; n++) begin
      idx = 16 + $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        d = {$urandom, $urandom}; b = 8'($urandom_range(0, 255));
        access(1'b1, DRAM_BASE + 64'(idx) * 8 + 64'($urandom_range(0, 7)), d, b, rd, er, vl);
        mem_model[idx] = merge(mem_model[idx], d, b);
        checks++; if ({vl, er} !== 2'b10) begin errors++; $display("[TB] FAIL rand_wr_resp got %b want 10", {vl, er}); end
      end else begin
        access(1'b0, DRAM_BASE + 64'(idx) * 8, 64'h0, 8'hFF, rd, er, vl);
        checks++; if (rd !== mem_model[idx] || vl !== 1'b1) begin errors++; $display("[TB] FAIL rand_rd[%0d] got %h want %h", idx, rd, mem_model[idx]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[$]; op_t o; int idx;
    o = '{1'b0, 64'h1000_0000, 64'h0, 8'hFF, 64'h0, 1'b1}; ops.push_back(o);
    o = '{1'b0, DRAM_BASE, 64'h0, 8'hFF, mem_model[0], 1'b0}; ops.push_back(o);
    for (int n = 0; n < 12; n++) begin
      idx = 16 + $urandom_range(0, 3);
      o.we = 1'(n % 2 == 0); o.addr = DRAM_BASE + 64'(idx) * 8;
      o.wdata = {$urandom, $urandom}; o.be = 8'($urandom_range(1, 255)); o.exp_err = 1'b0;
      o.exp = mem_model[idx];
      if (o.we) mem_model[idx] = merge(mem_model[idx], o.wdata, o.be);
      ops.push_back(o);
    end
    for (int i = 0; i <= ops.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (rvalid !== 1'b1 || err !== ops[i-1].exp_err || (!ops[i-1].we && rdata !== ops[i-1].exp)) begin
          errors++;
          $display("[TB] FAIL b2b[%0d] got v%b e%b %h want v1 e%b %h", i-1, rvalid, err, rdata, ops[i-1].exp_err, ops[i-1].exp);
        end
      end
      if (i < ops.size()) begin
        req = 1'b1; we = ops[i].we; addr = ops[i].addr; wdata = ops[i].wdata; be = ops[i].be;
      end else req = 1'b0;
    end
  endtask

  task automatic test_clint_regs();
    logic [63:0] rd, d; logic er, vl;
    access(1'b1, CLINT, 64'h1, 8'h01, rd, er, vl);
    checks++; if (ipi !== 1'b1) begin errors++; $display("[TB] FAIL ipi_set got %b want 1", ipi); end
    access(1'b0, CLINT, 64'h0, 8'hFF, rd, er, vl);
    checks++; if (rd !== 64'h1 || er !== 1'b0) begin errors++; $display("[TB] FAIL msip_rd got %h want 1", rd); end
    access(1'b1, CLINT, 64'h0, 8'h01, rd, er, vl);
    checks++; if (ipi !== 1'b0) begin errors++; $display("[TB] FAIL ipi_clr got %b want 0", ipi); end
    access(1'b1, CLINT + 64'h8, 64'h1, 8'h01, rd, er, vl);
    access(1'b0, CLINT + 64'h8, 64'h0, 8'hFF, rd, er, vl);
    checks++; if (rd !== 64'h1 || debug_req !== 1'b0) begin errors++; $display("[TB] FAIL dbg got rd %h req %b want 1/0", rd, debug_req); end
    d = {$urandom, $urandom};
    access(1'b1, CLINT + 64'h4000, d, 8'hFF, rd, er, vl);
    access(1'b0, CLINT + 64'h4000, 64'h0, 8'hFF, rd, er, vl);
    checks++; if (rd !== d) begin errors++; $display("[TB] FAIL mtimecmp_rd got %h want %h", rd, d); end
  endtask

  task automatic test_unmapped();
    logic [63:0] rd, a; logic er, vl;
    logic [63:0] addrs[5];
    addrs[0] = 64'h1000_0000;
    addrs[1] = DRAM_BASE + 64'(NW) * 8;
    addrs[2] = CLINT + 64'h10;
    addrs[3] = TOHOST + 64'h8;
    addrs[4] = 64'h1000_0000 + 64'($urandom_range(0, 4095)) * 8;
    for (int i = 0; i < 5; i++) begin
      a = addrs[i];
      access(1'b1, a, {$urandom, $urandom}, 8'hFF, rd, er, vl);
      checks++; if ({vl, er} !== 2'b11) begin errors++; $display("[TB] FAIL unmapped_wr %h got %b want 11", a, {vl, er}); end
      access(1'b0, a, 64'h0, 8'hFF, rd, er, vl);
      checks++; if ({vl, er} !== 2'b11 || rd !== 64'h0) begin errors++; $display("[TB] FAIL unmapped_rd %h got %b %h want 11 0", a, {vl, er}, rd); end
    end
  endtask

  task automatic test_timer();
    logic [63:0] rd; logic er, vl; bit seen;
    do_reset();
    access(1'b1, CLINT + 64'h4000, 64'd3, 8'hFF, rd, er, vl);
    rtc_pulse(); rtc_pulse();
    access(1'b0, CLINT + 64'hBFF8, 64'h0, 8'hFF, rd, er, vl);
    checks++; if (rd !== m_mtime || timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL mtime_2 got %h irq %b want %h irq 0", rd, timer_irq, m_mtime); end
    rtc = 1'b1; seen = 0;
    for (int c = 0; c < 7 && !seen; c++) begin @(negedge clk); if (timer_irq === 1'b1) seen = 1; end
    rtc = 1'b0; repeat (4) @(negedge clk);
    m_mtime = m_mtime + 64'd1;
    checks++; if (!seen) begin errors++; $display("[TB] FAIL timer_irq got 0 want 1 within bound"); end
    access(1'b0, CLINT + 64'hBFF8, 64'h0, 8'hFF, rd, er, vl);
    checks++; if (rd !== m_mtime) begin errors++; $display("[TB] FAIL mtime_3 got %h want %h", rd, m_mtime); end
    access(1'b1, CLINT + 64'hBFF8, 64'h0, 8'hFF, rd, er, vl);
    m_mtime = '0;
    repeat (2) @(negedge clk);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL timer_drop got %b want 0", timer_irq); end
    access(1'b1, CLINT + 64'hBFF8, '1, 8'hFF, rd, er, vl);
    m_mtime = '1;
    repeat (2) @(negedge clk);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("[TB] FAIL timer_max got %b want 1", timer_irq); end
    rtc_pulse();
    access(1'b0, CLINT + 64'hBFF8, 64'h0, 8'hFF, rd, er, vl);
    checks++; if (rd !== m_mtime || timer_irq !== 1'b0) begin errors++; $display("[TB] FAIL mtime_wrap got %h irq %b want %h irq 0", rd, timer_irq, m_mtime); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = DRAM_BASE; be = 8'hFF;
    @(posedge clk); #1;
    rst_n = 1'b0; req = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0 || rdata !== 64'h0) begin errors++; $display("[TB] FAIL reset_mid got %b %h want 0 0", rvalid, rdata); end
    @(negedge clk); rst_n = 1'b1; m_mtime = '0;
  endtask

  task automatic test_exit();
    logic [63:0] rd; logic er, vl; logic [31:0] m_exit;
    do_reset();
    access(1'b1, TOHOST, 64'h1, 8'hFF, rd, er, vl);
    checks++; if (exit_val !== 32'h1) begin errors++; $display("[TB] FAIL exit_pass got %h want 1", exit_val); end
    do_reset();
    checks++; if (exit_val !== 32'h0) begin errors++; $display("[TB] FAIL exit_reset got %h want 0", exit_val); end
    m_exit = 32'h0;
    access(1'b1, TOHOST, 64'hFFFF_FF00_0000_0015, 8'h01, rd, er, vl);
    if (!m_exit[0]) m_exit = 32'h15;
    checks++; if (exit_val !== m_exit || exit_val[31:1] !== 31'd10) begin errors++; $display("[TB] FAIL exit_code got %h want %h", exit_val, m_exit); end
    access(1'b1, TOHOST, 64'h0, 8'hFF, rd, er, vl);
    checks++; if (exit_val !== 32'h15) begin errors++; $display("[TB] FAIL exit_sticky got %h want 15", exit_val); end
    access(1'b0, TOHOST, 64'h0, 8'hFF, rd, er, vl);
    checks++; if (rd !== 64'h15 || er !== 1'b0) begin errors++; $display("[TB] FAIL exit_rd got %h want 15", rd); end
  endtask

  initial begin
    m_mtime = '0;
    test_reset();
    test_dram_basic();
    test_dram_random();
    test_back_to_back();
    test_clint_regs();
    test_unmapped();
    test_timer();
    test_reset_mid();
    test_exit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

endmodule
